// File: rtl/alu_seg_display.sv
// alu_seg_display: scans ALU operands and result onto a 4-digit
// common-anode seven-segment display, one consistent snapshot per frame.
module alu_seg_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] data_a,
    input  logic [3:0] data_b,
    input  logic [3:0] alu_out,
    input  logic       carry_flag,
    input  logic       freeze,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    snap_a;
    logic [3:0]    snap_b;
    logic [3:0]    snap_y;
    logic          snap_c;
    logic          load;
    logic [3:0]    nibble;
    logic [6:0]    seg_d;
    logic          dp_d;
    logic [3:0]    an_d;

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] f;
        case (v)
            4'h0:    f = 7'b1000000;
            4'h1:    f = 7'b1111001;
            4'h2:    f = 7'b0100100;
            4'h3:    f = 7'b0110000;
            4'h4:    f = 7'b0011001;
            4'h5:    f = 7'b0010010;
            4'h6:    f = 7'b0000010;
            4'h7:    f = 7'b1111000;
            4'h8:    f = 7'b0000000;
            4'h9:    f = 7'b0010000;
            4'hA:    f = 7'b0001000;
            4'hB:    f = 7'b0000011;
            4'hC:    f = 7'b1000110;
            4'hD:    f = 7'b0100001;
            4'hE:    f = 7'b0000110;
            default: f = 7'b0001110;
        endcase
        return f;
    endfunction

    // Snapshot only at frame start so a frame never mixes old and new values.
    assign load = (cnt == '0) && (idx == 2'd0) && !freeze;

    always_comb begin
        nibble = snap_y;
        unique case (idx)
            2'd0: nibble = snap_y;
            2'd1: nibble = {3'b000, snap_c};
            2'd2: nibble = snap_b;
            2'd3: nibble = snap_a;
        endcase
    end

    always_comb begin
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        an_d  = 4'b1111;
        if (cnt >= CNT_BLANK) begin
            seg_d = hex_font(nibble);
            dp_d  = (idx != 2'd2);
            an_d  = ~(4'b0001 << idx);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= 2'd0;
            snap_a <= 4'd0;
            snap_b <= 4'd0;
            snap_y <= 4'd0;
            snap_c <= 1'b0;
            seg    <= 7'b1111111;
            dp     <= 1'b1;
            an     <= 4'b1111;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (load) begin
                snap_a <= data_a;
                snap_b <= data_b;
                snap_y <= alu_out;
                snap_c <= carry_flag;
            end
            seg <= seg_d;
            dp  <= dp_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_alu_seg_display.sv
// tb_alu_seg_display: directed and random checks of the display scan
// against a frame-position reference model.
module tb_alu_seg_display;

    localparam int RDIV  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * RDIV;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] data_a = 4'd0;
    logic [3:0] data_b = 4'd0;
    logic [3:0] alu_out = 4'd0;
    logic       carry_flag = 1'b0;
    logic       freeze = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_seg_display #(
        .REFRESH_DIV (RDIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .data_a    (data_a),
        .data_b    (data_b),
        .alu_out   (alu_out),
        .carry_flag(carry_flag),
        .freeze    (freeze),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model state: position within the 32-cycle frame plus the snapshot.
    int         pos = 0;
    logic [3:0] s_a = 4'd0;
    logic [3:0] s_b = 4'd0;
    logic [3:0] s_y = 4'd0;
    logic       s_c = 1'b0;
    logic [11:0] exp_out = 12'hFFF;
    bit          have_exp = 1'b0;

    task automatic check(string tag, logic [11:0] got, logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [11:0] expect_at(int p);
        int slot;
        int phase;
        int val;
        slot  = p / RDIV;
        phase = p % RDIV;
        if (phase < BLANK) return 12'hFFF;
        case (slot)
            0:       val = int'(s_y);
            1:       val = int'(s_c);
            2:       val = int'(s_b);
            default: val = int'(s_a);
        endcase
        return {4'hF ^ (4'd1 << slot), (slot == 2) ? 1'b0 : 1'b1, font[val]};
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            pos = 0;
            s_a = 4'd0;
            s_b = 4'd0;
            s_y = 4'd0;
            s_c = 1'b0;
            exp_out = 12'hFFF;
        end else begin
            exp_out = expect_at(pos);
            if (pos == 0 && !freeze) begin
                s_a = data_a;
                s_b = data_b;
                s_y = alu_out;
                s_c = carry_flag;
            end
            pos = (pos + 1) % FRAME;
        end
        have_exp = 1'b1;
    end

    always @(negedge clock) begin
        if (have_exp) begin
            check("scan", {an, dp, seg}, exp_out);
            check("an_onecold", {11'd0, (an == 4'hF) || $onehot(~an)}, 12'd1);
            check("dp_digit2", {11'd0, dp || (an == 4'b1011)}, 12'd1);
        end
    end

    task automatic wait_pos(int p);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (pos != p && n < 4 * FRAME);
        check("wait_pos", 12'(pos), 12'(p));
    endtask

    initial begin
        // 1: reset, then capture of 3/5/8/0
        data_a = 4'h3;
        data_b = 4'h5;
        alu_out = 4'h8;
        carry_flag = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_blank", {an, dp, seg}, 12'hFFF);
        @(negedge clock);
        reset = 1'b0;
        wait_pos(4);
        check("t1_digit0", {an, dp, seg}, {4'b1110, 1'b1, 7'b0000000});
        wait_pos(20);
        check("t1_digit2", {an, dp, seg}, {4'b1011, 1'b0, 7'b0010010});

        // 2: steady F/A/9/1 over a full frame
        data_a = 4'hF;
        data_b = 4'hA;
        alu_out = 4'h9;
        carry_flag = 1'b1;
        wait_pos(0);
        begin
            int blanks;
            blanks = 0;
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clock);
                if (an == 4'hF) blanks++;
            end
            check("t2_blanks", 12'(blanks), 12'd8);
        end
        wait_pos(12);
        check("t2_digit1", {an, dp, seg}, {4'b1101, 1'b1, 7'b1111001});

        // 3: change alu_out mid-frame
        data_a = 4'h3;
        data_b = 4'h5;
        alu_out = 4'h8;
        carry_flag = 1'b0;
        wait_pos(9);
        alu_out = 4'h4;
        wait_pos(28);
        check("t3_digit3", {an, dp, seg}, {4'b0111, 1'b1, 7'b0110000});
        wait_pos(4);
        check("t3_digit0", {an, dp, seg}, {4'b1110, 1'b1, 7'b0011001});

        // 4: freeze across a frame boundary
        wait_pos(24);
        freeze = 1'b1;
        data_a = 4'h0;
        data_b = 4'h0;
        alu_out = 4'h0;
        wait_pos(4);
        check("t4_hold0", {an, dp, seg}, {4'b1110, 1'b1, 7'b0011001});
        wait_pos(20);
        check("t4_hold2", {an, dp, seg}, {4'b1011, 1'b0, 7'b0010010});
        freeze = 1'b0;
        wait_pos(4);
        check("t4_zero0", {an, dp, seg}, {4'b1110, 1'b1, 7'b1000000});
        wait_pos(20);
        check("t4_zero2", {an, dp, seg}, {4'b1011, 1'b0, 7'b1000000});
        wait_pos(28);
        check("t4_zero3", {an, dp, seg}, {4'b0111, 1'b1, 7'b1000000});

        // 5: reset at idx 2, cnt 5
        wait_pos(21);
        reset = 1'b1;
        alu_out = 4'h7;
        @(negedge clock);
        check("t5_blank", {an, dp, seg}, 12'hFFF);
        check("t5_cnt", 12'(dut.cnt), 12'd0);
        check("t5_idx", 12'(dut.idx), 12'd0);
        reset = 1'b0;
        wait_pos(4);
        check("t5_digit0", {an, dp, seg}, {4'b1110, 1'b1, 7'b1111000});

        // 6: random inputs, freeze and occasional reset
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            data_a = 4'($urandom);
            data_b = 4'($urandom);
            alu_out = 4'($urandom);
            carry_flag = 1'($urandom);
            freeze = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 99) == 0);
        end
        @(negedge clock);
        reset = 1'b0;
        freeze = 1'b0;
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seg_display.md
Name: alu_seg_display

Overview:
Downstream display stage for the 4-bit ALU on the BASYS3 board. Consumes the ALU operands and result (data_a, data_b, alu_out, carry_flag) and time-multiplexes them onto the board's 4-digit common-anode seven-segment display. A snapshot register makes sure every scan frame shows one consistent set of values. Inter-digit blanking suppresses ghosting.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz -> 1 kHz per digit, 250 Hz frame); legal range >= 4.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; legal range 2 .. REFRESH_DIV-1.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
data_a  input  4  ALU operand A.
data_b  input  4  ALU operand B.
alu_out  input  4  ALU result.
carry_flag  input  1  ALU carry/borrow flag.
freeze  input  1  1 = hold the current snapshot and ignore input changes.
seg  output  7  cathodes {g,f,e,d,c,b,a}, active low.
dp  output  1  decimal point, active low.
an  output  4  digit anodes, active low; an[0] is the rightmost digit.

Behaviour:
- One clock, `clock`. `reset` is synchronous and active-high. No other clock or reset.
- Reset values:
  - cnt = 0, idx = 0, snapshot = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
- Slot counter `cnt`, width clog2(REFRESH_DIV):
  - Counts 0 .. REFRESH_DIV-1, then wraps to 0.
  - On the wrap, digit index `idx` (2 bits) increments 3 -> 0 modulo 4.
- Snapshot:
  - In any cycle with cnt == 0, idx == 0 and freeze == 0, register {data_a, data_b, carry_flag, alu_out} at the clock edge.
  - freeze == 1 in that cycle: keep the old snapshot. The scan continues regardless.
  - The first cycle after reset meets the load condition, so live inputs are captured immediately.
- Digit map (from the snapshot):
  - idx 0 -> an[0] = alu_out, hex.
  - idx 1 -> an[1] = carry, shown as 0 or 1.
  - idx 2 -> an[2] = data_b, hex, with dp lit.
  - idx 3 -> an[3] = data_a, hex.
  - dp = 1 on all other digits.
- Blanking:
  - While cnt < BLANK_CYCLES: an = 4'b1111, seg = 7'b1111111, dp = 1.
  - Otherwise: only an[idx] = 0.
- Output timing:
  - an, seg and dp are registered. Their value in cycle k+1 is decoded from cnt, idx and snapshot in cycle k, so latency is 1 cycle.
  - A new snapshot is first visible at cnt == 2. BLANK_CYCLES >= 2 therefore guarantees no partially updated digit is ever shown.
- Hex font, seg = gfedcba, active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Input changes mid-frame have no visible effect until the next frame start.
- Reset asserted mid-slot: at the next edge all state returns to reset values, and outputs are blank in the following cycle.
- At most one anode is low in any cycle.

Test Plan:
(Bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2.)
1. Reset for 3 cycles, then release with data_a=3, data_b=5, alu_out=8, carry=0.
   -> During reset, an=1111 and seg=1111111.
   -> After release: idx0 slot cnt>=2 gives an=1110, seg=0000000; idx2 slot gives an=1011, seg=0010010, dp=0.
2. Steady inputs data_a=F, data_b=A, alu_out=9, carry=1; observe a full frame of 32 cycles.
   -> Each slot shows 2 blank cycles, then 6 cycles of the correct digit.
   -> Order: 9 on an[0], 1 on an[1], A on an[2] with dp=0, F on an[3].
3. Change alu_out from 8 to 4 while idx==1.
   -> Digit 0 keeps showing 8 for the rest of that frame.
   -> From the next frame, digit 0 shows 4 (seg=0011001).
4. freeze=1 across a frame boundary, inputs changed to all 0s.
   -> Old values persist.
   -> After freeze=0, the next frame shows 0 (seg=1000000) on digits 0, 2 and 3.
5. Assert reset at idx=2, cnt=5.
   -> Next cycle: all-blank outputs, cnt=0, idx=0.
   -> Normal scan resumes one cycle after reset drops.
6. Check over 1000 random cycles: the an one-cold-or-all-high invariant holds, and dp=0 only when an==1011.
